// File: rtl/npc_pkg.sv
// Shared constants and types for the fetch front end.
package npc_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam logic [XLEN-1:0] INST_BYTES       = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } ifu_state_e;

  // Instruction fetches must be word aligned.
  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding fetch, registered instruction
// presented to execute, pc redirect from execute, sticky misalignment halt.
module ifu
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic [XLEN-1:0] npc,
  input  logic            wen_pc,
  output logic            fetch_err
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic            req_valid_q, req_valid_d;
  logic            inst_valid_q, inst_valid_d;
  logic            fetch_err_q, fetch_err_d;

  logic            req_fire;
  logic            resp_fire;
  logic            inst_fire;
  logic [XLEN-1:0] next_pc;

  // req_valid_q is only ever set while the FSM sits in S_REQ.
  assign req_fire  = req_valid_q & imem_req_ready;
  assign resp_fire = (state_q == S_WAIT) & imem_resp_valid;
  assign inst_fire = (state_q == S_VALID) & inst_ready;
  assign next_pc   = wen_pc ? npc : (inst_pc_q + INST_BYTES);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_pc_d   = inst_pc_q;
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q;

    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp_fire) begin
          state_d   = S_VALID;
          inst_d    = imem_resp_data;
          inst_pc_d = pc_q;
        end
      end
      S_VALID: begin
        if (inst_fire) begin
          pc_d = next_pc;
          if (pc_misaligned(next_pc)) begin
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // Handshake outputs are registered copies of the next state.
    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_VALID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_pc_q    <= '0;
      inst_q       <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_q       <= inst_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_err      = fetch_err_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: scripted memory responses, scoreboard of
// expected (pc, instruction) pairs popped when decode sees the instruction.
module tb_ifu;
  import npc_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [63:0] npc = 64'h0;
  logic        wen_pc = 1'b0;
  logic        fetch_err;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  ifu #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .npc            (npc),
    .wen_pc         (wen_pc),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a fetch request; an expired bound counts as a failure.
  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL req_timeout: imem_req_valid=%b required 1 within 20 cycles", imem_req_valid);
    end
  endtask

  // Accept the next request and answer it one cycle later.
  task automatic serve(input logic [63:0] exp_pc, input logic [31:0] data);
    wait_req();
    imem_req_ready = 1'b1;
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    exp_q.push_back('{pc: exp_pc, ins: data});
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
  endtask

  task automatic handshake(input logic w, input logic [63:0] target);
    inst_ready = 1'b1;
    wen_pc     = w;
    npc        = target;
    tick();
    inst_ready = 1'b0;
    wen_pc     = 1'b0;
    npc        = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({imem_req_valid, inst_valid, fetch_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: req/inst_valid/err=%b required 000",
               {imem_req_valid, inst_valid, fetch_err});
    end
    n_tests++;
    if ({imem_addr, inst_pc, inst} !== {RST_PC, 64'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_regs: addr=%h inst_pc=%h inst=%h required %h 0 0",
               imem_addr, inst_pc, inst, RST_PC);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({imem_req_valid, imem_addr} !== {1'b1, RST_PC}) begin
      n_fail++;
      $display("FAIL reset_first_req: valid=%b addr=%h required 1 %h",
               imem_req_valid, imem_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    exp_t e;
    serve(64'h8000_0000, 32'h0000_0013);
    e = exp_q.pop_front();
    n_tests++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, e.pc, e.ins}) begin
      n_fail++;
      $display("FAIL seq_inst0: valid=%b pc=%h inst=%h required 1 %h %h",
               inst_valid, inst_pc, inst, e.pc, e.ins);
    end
    handshake(1'b0, 64'h0);
    n_tests++;
    if ({inst_valid, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 64'h8000_0004}) begin
      n_fail++;
      $display("FAIL seq_next_addr: ivalid=%b rvalid=%b addr=%h required 0 1 8000_0004",
               inst_valid, imem_req_valid, imem_addr);
    end
    serve(64'h8000_0004, 32'h0010_0093);
    e = exp_q.pop_front();
    n_tests++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, e.pc, e.ins}) begin
      n_fail++;
      $display("FAIL seq_inst1: valid=%b pc=%h inst=%h required 1 %h %h",
               inst_valid, inst_pc, inst, e.pc, e.ins);
    end
    handshake(1'b0, 64'h0);
    n_tests++;
    if (imem_addr !== 64'h8000_0008) begin
      n_fail++;
      $display("FAIL seq_addr2: addr=%h required 8000_0008", imem_addr);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    serve(64'h8000_0008, 32'h0002_0113);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      wen_pc = 1'b1;
      npc    = 64'h8000_0102;
      n_tests++;
      if ({inst_valid, imem_req_valid, inst_pc, inst} !== {2'b10, e.pc, e.ins}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: ivalid=%b rvalid=%b pc=%h inst=%h required 1 0 %h %h",
                 i, inst_valid, imem_req_valid, inst_pc, inst, e.pc, e.ins);
      end
      tick();
    end
    handshake(1'b0, 64'h0);
    n_tests++;
    if ({fetch_err, imem_req_valid, imem_addr} !== {2'b01, 64'h8000_000C}) begin
      n_fail++;
      $display("FAIL stall_release: err=%b rvalid=%b addr=%h required 0 1 8000_000c",
               fetch_err, imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    serve(64'h8000_000C, 32'h0000_0063);
    e = exp_q.pop_front();
    n_tests++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, e.pc, e.ins}) begin
      n_fail++;
      $display("FAIL redir_inst: valid=%b pc=%h inst=%h required 1 %h %h",
               inst_valid, inst_pc, inst, e.pc, e.ins);
    end
    handshake(1'b1, 64'h8000_0100);
    n_tests++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 64'h8000_0100}) begin
      n_fail++;
      $display("FAIL redir_addr: rvalid=%b addr=%h required 1 8000_0100",
               imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_same_cycle_resp();
    exp_t e;
    wait_req();
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_0001;
    tick();
    imem_resp_valid = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({inst_valid, imem_req_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL early_resp_ignored: ivalid=%b rvalid=%b required 0 0",
               inst_valid, imem_req_valid);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0030_0193;
    exp_q.push_back('{pc: 64'h8000_0100, ins: 32'h0030_0193});
    tick();
    imem_resp_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, e.pc, e.ins}) begin
      n_fail++;
      $display("FAIL late_resp_inst: valid=%b pc=%h inst=%h required 1 %h %h",
               inst_valid, inst_pc, inst, e.pc, e.ins);
    end
    handshake(1'b0, 64'h0);
    n_tests++;
    if (imem_addr !== 64'h8000_0104) begin
      n_fail++;
      $display("FAIL late_resp_next: addr=%h required 8000_0104", imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int unsigned c0, c1;
    serve(64'h8000_0104, 32'h0040_0213);
    e = exp_q.pop_front();
    handshake(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_req();
    c0 = cyc;
    serve(64'hFFFF_FFFF_FFFF_FFFC, 32'h0050_0293);
    e = exp_q.pop_front();
    n_tests++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, e.pc, e.ins}) begin
      n_fail++;
      $display("FAIL b2b_inst: valid=%b pc=%h inst=%h required 1 %h %h",
               inst_valid, inst_pc, inst, e.pc, e.ins);
    end
    handshake(1'b0, 64'h0);
    wait_req();
    c1 = cyc;
    n_tests++;
    if (c1 - c0 !== 3) begin
      n_fail++;
      $display("FAIL b2b_throughput: cycles=%0d required 3", c1 - c0);
    end
    n_tests++;
    if ({fetch_err, imem_addr} !== {1'b0, 64'h0}) begin
      n_fail++;
      $display("FAIL pc_wrap: err=%b addr=%h required 0 0", fetch_err, imem_addr);
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    serve(64'h0, 32'h0060_0313);
    e = exp_q.pop_front();
    handshake(1'b1, 64'h8000_0102);
    for (int i = 0; i < 6; i++) begin
      imem_req_ready  = 1'b1;
      imem_resp_valid = i[0];
      n_tests++;
      if ({fetch_err, inst_valid, imem_req_valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL halt[%0d]: err/ivalid/rvalid=%b required 100",
                 i, {fetch_err, inst_valid, imem_req_valid});
      end
      tick();
    end
    imem_resp_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({fetch_err, imem_req_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL halt_reset: err=%b rvalid=%b required 0 0", fetch_err, imem_req_valid);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({imem_req_valid, imem_addr} !== {1'b1, RST_PC}) begin
      n_fail++;
      $display("FAIL halt_restart: rvalid=%b addr=%h required 1 %h",
               imem_req_valid, imem_addr, RST_PC);
    end
  endtask

  task automatic test_stall_reset();
    exp_t e;
    serve(RST_PC, 32'h0070_0393);
    e = exp_q.pop_front();
    handshake(1'b1, 64'h8000_0200);
    imem_req_ready = 1'b0;
    wait_req();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({imem_req_valid, imem_addr} !== {1'b1, 64'h8000_0200}) begin
        n_fail++;
        $display("FAIL req_stall[%0d]: rvalid=%b addr=%h required 1 8000_0200",
                 i, imem_req_valid, imem_addr);
      end
      tick();
    end
    rst_n = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    n_tests++;
    if ({imem_req_valid, inst_valid, imem_addr} !== {2'b00, RST_PC}) begin
      n_fail++;
      $display("FAIL stall_reset: rvalid=%b ivalid=%b addr=%h required 0 0 %h",
               imem_req_valid, inst_valid, imem_addr, RST_PC);
    end
    rst_n = 1'b1;
    tick();
    tick();
    imem_resp_valid = 1'b0;
    n_tests++;
    if ({inst_valid, imem_req_valid, imem_addr, inst} !== {2'b01, RST_PC, 32'h0}) begin
      n_fail++;
      $display("FAIL stray_resp: ivalid=%b rvalid=%b addr=%h inst=%h required 0 1 %h 0",
               inst_valid, imem_req_valid, imem_addr, inst, RST_PC);
    end
    serve(RST_PC, 32'h0080_0413);
    e = exp_q.pop_front();
    n_tests++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, e.pc, e.ins}) begin
      n_fail++;
      $display("FAIL post_reset_inst: valid=%b pc=%h inst=%h required 1 %h %h",
               inst_valid, inst_pc, inst, e.pc, e.ins);
    end
    handshake(1'b0, 64'h0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_same_cycle_resp();
    test_back_to_back();
    test_misaligned();
    test_stall_reset();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
